// File: rtl/axis_pkt_gen_mc.sv
// AXI4-Stream packet generator with programmable length table, packet limit, stop and inter-packet gap.
// Optional statistics counters are enabled by defining AXIS_PKT_GEN_STATS_EN.
module axis_pkt_gen_mc #(
    parameter int unsigned DW      = 512,
    parameter int unsigned NUM_LEN = 8,
    parameter int unsigned LEN_W   = 13,
    parameter int unsigned SEQ_W   = 16,
    parameter int unsigned DEF_LEN = 64
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       start,
    input  logic                       stop,
    input  logic [31:0]                pkt_limit,
    input  logic [7:0]                 ipg,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_LEN)-1:0] cfg_addr,
    input  logic [LEN_W-1:0]           cfg_len,
    output logic                       busy,
    output logic                       done,
    output logic [DW-1:0]              axis_out_tdata,
    output logic [DW/8-1:0]            axis_out_tkeep,
    output logic                       axis_out_tlast,
    output logic [SEQ_W-1:0]           axis_out_tuser,
    output logic                       axis_out_tvalid,
    input  logic                       axis_out_tready
`ifdef AXIS_PKT_GEN_STATS_EN
    ,
    output logic [31:0]                stat_pkts,
    output logic [47:0]                stat_bytes
`endif
);

    localparam int unsigned DB = DW / 8;
    localparam int unsigned AW = $clog2(NUM_LEN);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  len_tab [NUM_LEN];
    logic [AW-1:0]     idx, load_idx;
    logic [LEN_W-1:0]  beat_cnt, last_beat, rem;
    logic [15:0]       data_cnt;
    logic [SEQ_W-1:0]  seq;
    logic [31:0]       pkts_sent, limit_r;
    logic [7:0]        ipg_r, gap_cnt;
    logic              stop_pend, done_r;
    logic              load, xfer, last_xfer, stop_now, limit_hit;
    logic [LEN_W-1:0]  ld_eff;
    int unsigned       eff_i;
    logic [DB-1:0]     keep_mask;

    assign xfer      = (state == S_SEND) && axis_out_tready;
    assign last_xfer = xfer && (beat_cnt == last_beat);
    assign stop_now  = stop_pend || stop;
    assign limit_hit = (limit_r != 32'd0) && ((pkts_sent + 32'd1) == limit_r);

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_idx  = idx;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SEND;
                    load      = 1'b1;
                    load_idx  = '0;
                end
            end
            S_SEND: begin
                if (last_xfer) begin
                    if (stop_now || limit_hit) begin
                        state_nxt = S_IDLE;
                    end else if (ipg_r != 8'd0) begin
                        state_nxt = S_GAP;
                    end else begin
                        state_nxt = S_SEND;
                        load      = 1'b1;
                        load_idx  = AW'(idx + 1'b1);
                    end
                end
            end
            S_GAP: begin
                // idx already advanced on the tlast transfer that entered the gap
                if (gap_cnt == 8'd1) begin
                    if (stop_now) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_SEND;
                        load      = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Zero-length entries behave as a single byte
    always_comb begin
        ld_eff = len_tab[load_idx];
        if (ld_eff == '0) ld_eff = LEN_W'(1);
        eff_i = 32'(ld_eff);
    end

    always_comb begin
        keep_mask = '0;
        for (int unsigned i = 0; i < DB; i++) keep_mask[i] = (i < 32'(rem));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NUM_LEN; i++) len_tab[i] <= LEN_W'(DEF_LEN);
            idx       <= '0;
            beat_cnt  <= '0;
            last_beat <= '0;
            rem       <= '0;
            data_cnt  <= '0;
            seq       <= '0;
            pkts_sent <= '0;
            limit_r   <= '0;
            ipg_r     <= '0;
            gap_cnt   <= '0;
            stop_pend <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            if (cfg_we) len_tab[cfg_addr] <= cfg_len;
            if (state == S_IDLE && start) begin
                limit_r   <= pkt_limit;
                ipg_r     <= ipg;
                data_cnt  <= 16'd1;
                seq       <= '0;
                idx       <= '0;
                pkts_sent <= '0;
            end
            if (xfer) begin
                data_cnt <= data_cnt + 16'd1;
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (last_xfer) begin
                seq       <= seq + 1'b1;
                idx       <= AW'(idx + 1'b1);
                pkts_sent <= pkts_sent + 32'd1;
                gap_cnt   <= ipg_r;
            end
            if (state == S_GAP) gap_cnt <= gap_cnt - 8'd1;
            if (load) begin
                beat_cnt  <= '0;
                last_beat <= LEN_W'((eff_i - 32'd1) / DB);
                rem       <= LEN_W'(eff_i % DB);
            end
            if (state_nxt == S_IDLE)                stop_pend <= 1'b0;
            else if (stop && state != S_IDLE)       stop_pend <= 1'b1;
            done_r <= (state != S_IDLE) && (state_nxt == S_IDLE);
        end
    end

`ifdef AXIS_PKT_GEN_STATS_EN
    logic [LEN_W-1:0] cur_len;
    logic [48:0]      bytes_sum;

    assign bytes_sum = {1'b0, stat_bytes} + 49'(cur_len);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cur_len    <= '0;
            stat_pkts  <= '0;
            stat_bytes <= '0;
        end else begin
            if (load) cur_len <= ld_eff;
            if (last_xfer) begin
                if (stat_pkts != '1) stat_pkts <= stat_pkts + 32'd1;
                stat_bytes <= bytes_sum[48] ? '1 : bytes_sum[47:0];
            end
        end
    end
`endif

    assign busy            = (state != S_IDLE);
    assign done            = done_r;
    assign axis_out_tvalid = (state == S_SEND);
    assign axis_out_tlast  = axis_out_tvalid && (beat_cnt == last_beat);
    assign axis_out_tdata  = {(DW/16){data_cnt}};
    assign axis_out_tuser  = seq;
    assign axis_out_tkeep  = !axis_out_tvalid ? '0 :
                             (axis_out_tlast && rem != '0) ? keep_mask : '1;

endmodule

// File: tb/tb_axis_pkt_gen_mc.sv
// Scoreboard bench for axis_pkt_gen_mc (DW=64, NUM_LEN=8); checks stats when AXIS_PKT_GEN_STATS_EN is defined.
module tb_axis_pkt_gen_mc;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] pkt_limit = '0;
    logic [7:0]  ipg = '0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [12:0] cfg_len = '0;
    logic        busy, done;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast, tvalid;
    logic [15:0] tuser;
    logic        tready = 1'b1;
`ifdef AXIS_PKT_GEN_STATS_EN
    logic [31:0] stat_pkts;
    logic [47:0] stat_bytes;
`endif

    axis_pkt_gen_mc #(.DW(64), .NUM_LEN(8), .LEN_W(13), .SEQ_W(16), .DEF_LEN(64)) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop),
        .pkt_limit(pkt_limit), .ipg(ipg),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
        .busy(busy), .done(done),
        .axis_out_tdata(tdata), .axis_out_tkeep(tkeep), .axis_out_tlast(tlast),
        .axis_out_tuser(tuser), .axis_out_tvalid(tvalid), .axis_out_tready(tready)
`ifdef AXIS_PKT_GEN_STATS_EN
        , .stat_pkts(stat_pkts), .stat_bytes(stat_bytes)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [15:0] user;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          bubbles = 0;
    int          first_seen = 0;
    bit          sb_en = 1'b1;
    bit          rand_ready = 1'b0;
    bit          in_pkt = 1'b0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic [7:0]  prev_keep;
    logic        prev_last;
    logic [15:0] prev_user;
    logic [15:0] exp_data;
    logic [15:0] exp_seq;

    initial begin
        forever begin
            @(posedge clk);
            #1 tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard pop on each transfer and hold-stability under backpressure
    always @(negedge clk) begin
        if (!resetn) begin
            in_pkt     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (busy && !tvalid) bubbles++;
            if (done) done_cnt++;
            if (sb_en && prev_stall) begin
                checks++;
                if (tvalid !== 1'b1 || tdata !== prev_data || tkeep !== prev_keep ||
                    tlast !== prev_last || tuser !== prev_user) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b d=%h k=%h l=%b u=%h, want v=1 d=%h k=%h l=%b u=%h",
                             tvalid, tdata, tkeep, tlast, tuser, prev_data, prev_keep, prev_last, prev_user);
                end
            end
            if (tvalid && tready) begin
                if (!in_pkt) first_seen++;
                in_pkt = !tlast;
                if (sb_en) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got d=%h k=%h l=%b u=%h, want no beat",
                                 tdata, tkeep, tlast, tuser);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        if (tdata !== {4{e.data}} || tkeep !== e.keep || tlast !== e.last || tuser !== e.user) begin
                            errors++;
                            $display("FAIL beat: got d=%h k=%h l=%b u=%h, want d=%h k=%h l=%b u=%h",
                                     tdata, tkeep, tlast, tuser, {4{e.data}}, e.keep, e.last, e.user);
                        end
                    end
                end
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_keep  = tkeep;
            prev_last  = tlast;
            prev_user  = tuser;
        end
    end

    task automatic push_beat(input logic [15:0] d, input logic [7:0] k, input logic l, input logic [15:0] u);
        beat_t b;
        b.data = d; b.keep = k; b.last = l; b.user = u;
        exp_q.push_back(b);
    endtask

    // Expected beats of one packet of len bytes, 8 bytes per beat
    task automatic push_pkt(input int len);
        int eff, beats, rem;
        eff   = (len == 0) ? 1 : len;
        beats = (eff + 7) / 8;
        rem   = eff % 8;
        for (int b = 0; b < beats; b++) begin
            logic [7:0] k;
            k = (b == beats - 1 && rem != 0) ? 8'((1 << rem) - 1) : 8'hFF;
            push_beat(exp_data, k, b == beats - 1, exp_seq);
            exp_data = exp_data + 16'd1;
        end
        exp_seq = exp_seq + 16'd1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [12:0] l);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = a; cfg_len = l;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] lim, input logic [7:0] gap);
        @(posedge clk); #1;
        start = 1'b1; pkt_limit = lim; ipg = gap;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Bounded wait for the end of a run, then check the done pulse and busy
    task automatic wait_run_end(input string name, input int base_done);
        int n = 0;
        while (done_cnt == base_done && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        checks++;
        if (done_cnt != base_done + 1) begin
            errors++;
            $display("FAIL %s_done_pulses: got %0d, want 1", name, done_cnt - base_done);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_end: got %b, want 0", name, busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_beats: got %0d left, want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (tvalid !== 1'b0)   begin errors++; $display("FAIL rst_tvalid: got %b, want 0", tvalid); end
        checks++; if (tlast !== 1'b0)    begin errors++; $display("FAIL rst_tlast: got %b, want 0", tlast); end
        checks++; if (tkeep !== 8'h00)   begin errors++; $display("FAIL rst_tkeep: got %h, want 00", tkeep); end
        checks++; if (tdata !== 64'h0)   begin errors++; $display("FAIL rst_tdata: got %h, want 0", tdata); end
        checks++; if (tuser !== 16'h0)   begin errors++; $display("FAIL rst_tuser: got %h, want 0", tuser); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b, want 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL rst_done: got %b, want 0", done); end
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_basic;
        int base;
        cfg_write(3'd0, 13'd18);
        cfg_write(3'd1, 13'd8);
        cfg_write(3'd2, 13'd1);
        push_beat(16'd1, 8'hFF, 1'b0, 16'd0);
        push_beat(16'd2, 8'hFF, 1'b0, 16'd0);
        push_beat(16'd3, 8'h03, 1'b1, 16'd0);
        push_beat(16'd4, 8'hFF, 1'b1, 16'd1);
        push_beat(16'd5, 8'h01, 1'b1, 16'd2);
        base = done_cnt;
        bubbles = 0;
        do_start(32'd3, 8'd0);
        wait_run_end("basic", base);
        checks++;
        if (bubbles != 0) begin errors++; $display("FAIL basic_bubbles: got %0d, want 0", bubbles); end
`ifdef AXIS_PKT_GEN_STATS_EN
        checks++; if (stat_pkts !== 32'd3)  begin errors++; $display("FAIL stat_pkts_1: got %0d, want 3", stat_pkts); end
        checks++; if (stat_bytes !== 48'd27) begin errors++; $display("FAIL stat_bytes_1: got %0d, want 27", stat_bytes); end
`endif
    endtask

    task automatic test_backpressure;
        int base;
        exp_data = 16'd1; exp_seq = 16'd0;
        push_pkt(18); push_pkt(8); push_pkt(1);
        base = done_cnt;
        rand_ready = 1'b1;
        do_start(32'd3, 8'd0);
        wait_run_end("bp", base);
        rand_ready = 1'b0;
`ifdef AXIS_PKT_GEN_STATS_EN
        checks++; if (stat_pkts !== 32'd6)  begin errors++; $display("FAIL stat_pkts_2: got %0d, want 6", stat_pkts); end
        checks++; if (stat_bytes !== 48'd54) begin errors++; $display("FAIL stat_bytes_2: got %0d, want 54", stat_bytes); end
`endif
    endtask

    task automatic test_stop_gap;
        int base, n;
        cfg_write(3'd1, 13'd40);
        exp_data = 16'd1; exp_seq = 16'd0;
        push_pkt(18); push_pkt(40);
        base = done_cnt;
        first_seen = 0;
        bubbles = 0;
        do_start(32'd0, 8'd4);
        n = 0;
        while (first_seen < 2 && n < 500) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (first_seen < 2) begin errors++; $display("FAIL stop_second_pkt: got %0d packets, want 2", first_seen); end
        #1 stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        wait_run_end("stop", base);
        checks++;
        if (bubbles != 4) begin errors++; $display("FAIL stop_gap_cycles: got %0d, want 4", bubbles); end
        checks++;
        if (first_seen != 2) begin errors++; $display("FAIL stop_pkt_count: got %0d, want 2", first_seen); end
    endtask

    task automatic test_cfg_wrap;
        int base;
        cfg_write(3'd0, 13'd64);
        cfg_write(3'd1, 13'd8);
        for (int i = 2; i < 8; i++) cfg_write(3'(i), 13'd8);
        exp_data = 16'd1; exp_seq = 16'd0;
        push_pkt(64); push_pkt(0);
        for (int i = 2; i < 8; i++) push_pkt(8);
        push_pkt(64); push_pkt(0);
        base = done_cnt;
        do_start(32'd10, 8'd0);
        cfg_write(3'd1, 13'd0);
        wait_run_end("cfg", base);
    endtask

    task automatic test_reset_mid;
        int base;
        cfg_write(3'd0, 13'd16);
        sb_en = 1'b0;
        do_start(32'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b0;
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_len = 13'd8;
        @(posedge clk); #1;
        resetn = 1'b1;
        cfg_we = 1'b0;
        @(negedge clk);
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b, want 0", tvalid); end
        checks++; if (tlast !== 1'b0)  begin errors++; $display("FAIL midrst_tlast: got %b, want 0", tlast); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL midrst_busy: got %b, want 0", busy); end
        exp_q.delete();
        sb_en = 1'b1;
        exp_data = 16'd1; exp_seq = 16'd0;
        push_pkt(64);
        base = done_cnt;
        do_start(32'd1, 8'd0);
        wait_run_end("midrst", base);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stop_gap();
        test_cfg_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_pkt_gen_mc.md
Name: axis_pkt_gen_mc

Overview:
Parametrised AXI4-Stream packet generator, the successor to the single-table fixed-sequence generator used for FIFO/datapath bring-up. It adds a runtime-programmable packet-length table, a packet-count limit, graceful stop at packet boundaries, a programmable inter-packet gap and a per-packet sequence number on tuser. It sits at the head of test datapaths and feeds AXIS FIFOs or DMA under test.

Parameters:
DW, 512, tdata width in bits; multiple of 16, minimum 16.
NUM_LEN, 8, length-table depth; power of 2, minimum 2.
LEN_W, 13, width of each length entry in bytes; maximum packet length is 2^LEN_W-1.
SEQ_W, 16, width of the packet sequence number carried on tuser.
DEF_LEN, 64, reset value of every length-table entry.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins generation from IDLE
stop  in  1  one-cycle pulse; request to halt after the current packet
pkt_limit  in  32  packets to send per run; 0 = unlimited; sampled on start
ipg  in  8  idle cycles between packets; sampled on start
cfg_we  in  1  length-table write strobe
cfg_addr  in  log2(NUM_LEN)  length-table write index
cfg_len  in  LEN_W  length-table write data in bytes
busy  out  1  high from accepted start until the run ends
done  out  1  one-cycle pulse when a run ends
axis_out_tdata  out  DW  payload
axis_out_tkeep  out  DW/8  byte enables
axis_out_tlast  out  1  last beat of packet
axis_out_tuser  out  SEQ_W  packet sequence number, constant across a packet
axis_out_tvalid  out  1  beat valid
axis_out_tready  in  1  downstream ready

Behaviour:
- Reset and clock: resetn is synchronous and active-low; clk is the clock. Reset may be asserted at any time, including mid-packet. On reset, the FSM goes to IDLE and the outputs become: tvalid=0, tlast=0, tkeep=0, tdata=0, tuser=0, busy=0, done=0. Every table entry becomes DEF_LEN, and the sequence, data and packet counters clear. A reset mid-packet truncates the packet with no tlast.
- Byte width and length handling: DB=DW/8. At each packet start, len=table[idx] is latched; len=0 is treated as 1. beats = ceil(len/DB) and rem = len mod DB.
- Handshake: a beat transfers when tvalid && tready. While tvalid is high and tready is low, tdata, tkeep, tlast and tuser hold stable. tvalid never drops mid-packet except on reset.
- tdata: a 16-bit counter, replicated DW/16 times. It is set to 1 on start and increments per transferred beat, wrapping at 0xFFFF to 0x0000.
- tkeep: all ones, except on the tlast beat when rem!=0, where it is (1<<rem)-1 (LSB-aligned).
- tuser: set to 0 on start and increments by 1 after each tlast transfer, wrapping modulo 2^SEQ_W.
- idx: set to 0 on start and increments after each tlast transfer, wrapping NUM_LEN-1 -> 0.
- FSM IDLE: start moves to SEND. pkt_limit and ipg are latched, busy is set, and tvalid rises on the next cycle. start is ignored in any other state.
- FSM SEND: on a tlast transfer, the next state is chosen as follows.
  - If stop is pending, or pkt_limit!=0 and packets_sent==pkt_limit, go to IDLE: busy=0 and done pulses for one cycle.
  - Otherwise, if ipg!=0, go to GAP.
  - Otherwise stay in SEND, with the next packet's first beat presented back-to-back in the next cycle.
- FSM GAP: tvalid=0 for exactly ipg cycles, then SEND. A stop arriving during GAP goes to IDLE at the end of the gap, with done pulsed.
- stop: sets a pending flag in any non-IDLE state; the flag clears on entry to IDLE. A stop arriving in the same cycle as a tlast transfer counts for that packet, so the run ends there. stop in IDLE is ignored.
- Length table writes: allowed at any time. A write takes effect for packets latched after the write cycle. A write in the same cycle as a latch of the same index returns the old value. Writes during reset are ignored.
- packets_sent: 32 bits, cleared on start.

Optional Feature:
Macro AXIS_PKT_GEN_STATS_EN.
- Defined: adds outputs stat_pkts (32 bits) and stat_bytes (48 bits). They count transferred packets and bytes (sum of latched len per completed packet). They clear on reset only, not on start, and saturate at all ones.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- DW=64; table[0..2]={18,8,1}; pkt_limit=3, ipg=0, tready=1 -> three packets.
  - Beats 3/1/1.
  - Last tkeep 0x03, 0xFF, 0x01; tuser 0,1,2.
  - tdata counter 1..5 with no bubbles.
  - Then done is one pulse and busy=0.
- Same setup, tready toggled pseudo-randomly -> identical beat sequence; outputs stable whenever tvalid && !tready.
- pkt_limit=0, ipg=4, stop pulsed mid-second packet -> second packet completes with tlast and exactly 4 idle cycles separate packets; IDLE after the second packet, done pulses once.
- Write cfg_addr=1, cfg_len=0 while busy -> the next packet at idx 1 is 1 beat with tkeep 0x01; idx wraps 7->0 after 8 packets (NUM_LEN=8).
- Assert resetn=0 for 1 cycle mid-packet -> tvalid=0 the next cycle, table back to DEF_LEN=64; a subsequent start gives a 64-byte packet (8 beats), tuser=0, tdata starting at 1.
- With AXIS_PKT_GEN_STATS_EN defined: after the first scenario, stat_pkts=3 and stat_bytes=27; start again -> counters keep accumulating (not cleared).
